// File: rtl/nibble_alu_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract unit.
// The controller and its single nibble slice both import this package.
package nibble_alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands agree in sign but the result does not.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit a + b + cin with carry lookahead.
// Subtraction is handled upstream, so the slice has no mode input.
module nibble_addsub_slice
  import nibble_alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is expanded directly from cin, so no carry ripples between bits.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[NIB_W-1:0];
  assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract unit that reuses one nibble slice, LSB nibble first.
// A request is latched in IDLE, processed over NIB cycles, and held in DONE until consumed.
module nibble_serial_addsub
  import nibble_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_zero
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [NIB_W-1:0] w_slice_s;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_sum_next;

  nibble_addsub_slice u_slice (
    .a    (r_a[NIB_W*r_idx +: NIB_W]),
    .b    (r_b[NIB_W*r_idx +: NIB_W]),
    .cin  (r_carry),
    .s    (w_slice_s),
    .cout (w_slice_cout)
  );

  // Running sum with the current nibble merged in; the zero flag needs the complete value.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[NIB_W*r_idx +: NIB_W] = w_slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a     <= req_a;
            r_b     <= req_b ^ {WIDTH{req_sub}};
            r_carry <= req_sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= ovf_detect(r_a[WIDTH-1], r_b[WIDTH-1], w_slice_s[NIB_W-1]);
            r_zero  <= (w_sum_next == '0);
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == DONE);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;
  assign rsp_zero  = r_zero;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomised and directed bench for nibble_serial_addsub (WIDTH=16).
// Results come from a plain-arithmetic model queued at each accepted request.
module tb_nibble_serial_addsub;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic             rsp_zero;

  int totalChecks = 0;
  int badChecks   = 0;
  int cycleCount  = 0;
  int popCount    = 0;
  int latencyDone = -1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    int               acceptCycle;
  } exp_t;

  exp_t expQ[$];

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t modelOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int u;
    int s;
    if (sub) begin
      u      = ua - ub;
      s      = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      u      = ua + ub;
      s      = sa + sb;
      e.cout = (u > 65535);
    end
    e.sum         = WIDTH'(u & 32'hFFFF);
    e.ovf         = (s > 32767) || (s < -32768);
    e.zero        = (e.sum == 0);
    e.acceptCycle = 0;
    return e;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic req);
    totalChecks++;
    if (act !== req) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0b want %0b at cycle %0d", name, act, req, cycleCount);
    end
  endtask

  task automatic checkWord(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    totalChecks++;
    if (act !== req) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h want %h at cycle %0d", name, act, req, cycleCount);
    end
  endtask

  // Track accepted requests and consumed responses; reset discards anything in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
      popCount++;
    end else begin
      cycleCount++;
      if (rsp_valid && rsp_ready && expQ.size() > 0) begin
        void'(expQ.pop_front());
        popCount++;
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e = modelOp(req_a, req_b, req_sub);
        e.acceptCycle = cycleCount;
        expQ.push_back(e);
      end
    end
  end

  // Every cycle a response is presented it must match the model and the block must be busy.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (expQ.size() == 0) begin
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL stale_valid: got rsp_valid=1 want 0 at cycle %0d", cycleCount);
      end else begin
        checkWord("sum", rsp_sum, expQ[0].sum);
        checkBit("cout", rsp_cout, expQ[0].cout);
        checkBit("ovf", rsp_ovf, expQ[0].ovf);
        checkBit("zero", rsp_zero, expQ[0].zero);
        checkBit("req_ready_busy", req_ready, 1'b0);
        if (latencyDone != popCount) begin
          latencyDone = popCount;
          totalChecks++;
          if (cycleCount - expQ[0].acceptCycle != NIB) begin
            badChecks++;
            $display("[TB] FAIL latency: got %0d want %0d", cycleCount - expQ[0].acceptCycle, NIB);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    int n = 0;
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      totalChecks++;
      badChecks++;
      $display("[TB] FAIL accept_timeout: got req_ready=0 want 1");
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      totalChecks++;
      badChecks++;
      $display("[TB] FAIL rsp_timeout: got rsp_valid=0 want 1");
    end
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] s, input logic c,
                             input logic o, input logic z);
    waitValid();
    checkWord({name, "_sum"}, rsp_sum, s);
    checkBit({name, "_cout"}, rsp_cout, c);
    checkBit({name, "_ovf"}, rsp_ovf, o);
    checkBit({name, "_zero"}, rsp_zero, z);
    rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    logic [WIDTH-1:0] pick [4];
    pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = 1'b0;
    rsp_ready = 1'b1;
    #23;
    checkBit("reset_valid", rsp_valid, 1'b0);
    checkWord("reset_sum", rsp_sum, '0);
    checkBit("reset_cout", rsp_cout, 1'b0);
    rst_n = 1'b1;
    tick();
    checkBit("reset_ready", req_ready, 1'b1);

    applyStimulus(16'h1234, 16'h0FFF, 1'b0);
    checkOutput("add", 16'h2233, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput("ovf_add", 16'h8000, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    checkOutput("ovf_sub", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1);
    checkOutput("borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE for 10 cycles with the next request already waiting.
    rsp_ready = 1'b0;
    applyStimulus(16'hA5A5, 16'h1111, 1'b0);
    waitValid();
    req_a     = 16'h0102;
    req_b     = 16'h0304;
    req_sub   = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkBit("bp_ready", req_ready, 1'b0);
      checkWord("bp_sum", rsp_sum, 16'hB6B6);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkBit("bp_idle_ready", req_ready, 1'b1);
    checkBit("bp_idle_valid", rsp_valid, 1'b0);
    tick();
    checkBit("bp_accepted", req_ready, 1'b0);
    req_valid = 1'b0;
    checkOutput("bp_next", 16'h0406, 1'b0, 1'b0, 1'b0);

    // Reset during the second RUN cycle.
    req_a     = 16'h4321;
    req_b     = 16'h1111;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkWord("rst_sum", rsp_sum, '0);
    checkBit("rst_valid", rsp_valid, 1'b0);
    checkBit("rst_ovf", rsp_ovf, 1'b0);
    checkBit("rst_zero", rsp_zero, 1'b0);
    #4;
    rst_n = 1'b1;
    tick();
    checkBit("rst_ready", req_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkBit("rst_no_stale", rsp_valid, 1'b0);
      tick();
    end
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    checkOutput("post_rst", 16'h0002, 1'b0, 1'b0, 1'b0);

    // Random traffic with random backpressure; the compare process does the checking.
    for (int t = 0; t < 60; t++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic done;
      int n;
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      applyStimulus(a, b, 1'($urandom_range(0, 1)));
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
        rsp_ready = 1'($urandom_range(0, 1));
        done = rsp_valid && rsp_ready;
        tick();
        n++;
      end
      if (!done) begin
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL rand_handshake: got no handshake want one within 200 cycles");
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    rsp_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
